// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : opcodes and FSM state encoding shared by the sequential ALU |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

   localparam logic [5:0] OP_SLL = 6'b000000;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_shift_unit.sv
// +----------------------------------------------------------------------+
// | alu_shift_unit : iterative shifter, one bit per i_step while cnt != 0 |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_shift_unit #(
   parameter int NB_DATA  = 8,
   parameter int NB_SHAMT = 3
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_load,
   input  logic [NB_DATA-1:0]  i_value,
   input  logic [NB_SHAMT-1:0] i_shamt,
   input  logic                i_step,
   input  logic                i_dir,
   input  logic                i_arith,
   output logic [NB_DATA-1:0]  o_value,
   output logic                o_bit,
   output logic                o_done
);

   logic [NB_DATA-1:0]  value_q, value_d;
   logic [NB_SHAMT-1:0] cnt_q, cnt_d;
   logic                bit_q, bit_d;

   always_comb begin
      value_d = value_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      if (i_load) begin
         value_d = i_value;
         cnt_d   = i_shamt;
         bit_d   = 1'b0;
      end else if (i_step && (cnt_q != '0)) begin
         cnt_d = cnt_q - NB_SHAMT'(1);
         // i_dir: 0 = left, 1 = right; i_arith keeps the sign on right shifts
         if (i_dir) begin
            bit_d   = value_q[0];
            value_d = {i_arith & value_q[NB_DATA-1], value_q[NB_DATA-1:1]};
         end else begin
            bit_d   = value_q[NB_DATA-1];
            value_d = {value_q[NB_DATA-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         value_q <= '0;
         cnt_q   <= '0;
         bit_q   <= 1'b0;
      end else begin
         value_q <= value_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
      end
   end

   assign o_value = value_q;
   assign o_bit   = bit_q;
   assign o_done  = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +----------------------------------------------------------------------+
// | alu_seq : registered, handshaked ALU with iterative shifts            |
// | optional macro ALU_SIGNED_FLAGS_EN adds o_overflow / o_negative       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_seq
   import alu_pkg::*;
#(
   parameter int NB_DATA  = 8,
   parameter int NB_OP    = 6,
   parameter int NB_SHAMT = $clog2(NB_DATA)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_enable_1,
   input  logic               i_enable_2,
   input  logic               i_enable_3,
   input  logic               i_start,
   input  logic               i_ready,
   output logic               o_busy,
   output logic               o_valid,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_carry,
   output logic               o_zero
`ifdef ALU_SIGNED_FLAGS_EN
  ,output logic               o_overflow,
   output logic               o_negative
`endif
);

   state_t             state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, wa_q, wa_d, wb_q, wb_d;
   logic [NB_OP-1:0]   op_q, op_d, wop_q, wop_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               carry_q, carry_d, zero_q, zero_d;
`ifdef ALU_SIGNED_FLAGS_EN
   logic               ovf_q, ovf_d, neg_q, neg_d, w_ovf;
`endif

   logic [NB_DATA-1:0] w_result, sh_value;
   logic [NB_DATA:0]   w_sum, w_diff;
   logic               w_carry, w_is_shift, sh_load, sh_step, sh_bit, sh_done;

   assign w_is_shift = (wop_q == NB_OP'(OP_SLL)) || (wop_q == NB_OP'(OP_SRL)) ||
                       (wop_q == NB_OP'(OP_SRA));

   alu_shift_unit #(.NB_DATA(NB_DATA), .NB_SHAMT(NB_SHAMT)) u_shift (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (sh_load),
      .i_value (a_q),
      .i_shamt (b_q[NB_SHAMT-1:0]),
      .i_step  (sh_step),
      .i_dir   (wop_q != NB_OP'(OP_SLL)),
      .i_arith (wop_q == NB_OP'(OP_SRA)),
      .o_value (sh_value),
      .o_bit   (sh_bit),
      .o_done  (sh_done)
   );

   assign w_sum  = {1'b0, wa_q} + {1'b0, wb_q};
   assign w_diff = {1'b0, wa_q} - {1'b0, wb_q};

   always_comb begin
      w_result = '0;
      w_carry  = 1'b0;
      case (wop_q)
         NB_OP'(OP_ADD): {w_carry, w_result} = w_sum;
         NB_OP'(OP_SUB): begin
            w_result = w_diff[NB_DATA-1:0];
            w_carry  = ~w_diff[NB_DATA];
         end
         NB_OP'(OP_AND): w_result = wa_q & wb_q;
         NB_OP'(OP_OR):  w_result = wa_q | wb_q;
         NB_OP'(OP_XOR): w_result = wa_q ^ wb_q;
         NB_OP'(OP_NOR): w_result = ~(wa_q | wb_q);
         NB_OP'(OP_SLL), NB_OP'(OP_SRL), NB_OP'(OP_SRA): begin
            w_result = sh_value;
            w_carry  = sh_bit;
         end
         default: ;
      endcase
   end

`ifdef ALU_SIGNED_FLAGS_EN
   always_comb begin
      w_ovf = 1'b0;
      if (wop_q == NB_OP'(OP_ADD))
         w_ovf = (wa_q[NB_DATA-1] == wb_q[NB_DATA-1]) && (w_sum[NB_DATA-1] != wa_q[NB_DATA-1]);
      else if (wop_q == NB_OP'(OP_SUB))
         w_ovf = (wa_q[NB_DATA-1] != wb_q[NB_DATA-1]) && (w_diff[NB_DATA-1] != wa_q[NB_DATA-1]);
   end
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      wa_d    = wa_q;
      wb_d    = wb_q;
      wop_d   = wop_q;
      data_d  = data_q;
      carry_d = carry_q;
      zero_d  = zero_q;
`ifdef ALU_SIGNED_FLAGS_EN
      ovf_d   = ovf_q;
      neg_d   = neg_q;
`endif
      sh_load = 1'b0;
      sh_step = 1'b0;

      // operand registers are frozen while an op is executing
      if (state_q != ST_EXEC) begin
         if (i_enable_1)      a_d  = i_data;
         else if (i_enable_2) b_d  = i_data;
         else if (i_enable_3) op_d = i_data[NB_OP-1:0];
      end

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               wa_d    = a_q;
               wb_d    = b_q;
               wop_d   = op_q;
               sh_load = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (w_is_shift && !sh_done) begin
               sh_step = 1'b1;
            end else begin
               data_d  = w_result;
               carry_d = w_carry;
               zero_d  = (w_result == '0);
`ifdef ALU_SIGNED_FLAGS_EN
               ovf_d   = w_ovf;
               neg_d   = w_result[NB_DATA-1];
`endif
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         wa_q    <= '0;
         wb_q    <= '0;
         wop_q   <= '0;
         data_q  <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
`ifdef ALU_SIGNED_FLAGS_EN
         ovf_q   <= 1'b0;
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         wa_q    <= wa_d;
         wb_q    <= wb_d;
         wop_q   <= wop_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
`ifdef ALU_SIGNED_FLAGS_EN
         ovf_q   <= ovf_d;
         neg_q   <= neg_d;
`endif
      end
   end

   assign o_busy  = (state_q != ST_IDLE);
   assign o_valid = (state_q == ST_DONE);
   assign o_data  = data_q;
   assign o_carry = carry_q;
   assign o_zero  = zero_q;
`ifdef ALU_SIGNED_FLAGS_EN
   assign o_overflow = ovf_q;
   assign o_negative = neg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +----------------------------------------------------------------------+
// | tb_alu_seq : directed + random bench for alu_seq (NB_DATA = 8)        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [7:0] i_data = '0;
   logic       i_enable_1 = 1'b0, i_enable_2 = 1'b0, i_enable_3 = 1'b0;
   logic       i_start = 1'b0, i_ready = 1'b0;
   logic       o_busy, o_valid, o_carry, o_zero;
   logic [7:0] o_data;
`ifdef ALU_SIGNED_FLAGS_EN
   logic       o_overflow, o_negative;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] cur_a = '0, cur_b = '0;
   logic [5:0] cur_op = '0;

   always #5 clk = ~clk;

   alu_seq dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_data     (i_data),
      .i_enable_1 (i_enable_1),
      .i_enable_2 (i_enable_2),
      .i_enable_3 (i_enable_3),
      .i_start    (i_start),
      .i_ready    (i_ready),
      .o_busy     (o_busy),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_carry    (o_carry),
      .o_zero     (o_zero)
`ifdef ALU_SIGNED_FLAGS_EN
     ,.o_overflow (o_overflow),
      .o_negative (o_negative)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the opcode table.
   task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        output logic [7:0] r, output logic c, output logic v, output int lat);
      int sh, s, sa, sb, sr;
      logic signed [7:0] as_s;
      sh = int'(b[2:0]);
      sa = int'($signed(a));
      sb = int'($signed(b));
      as_s = a;
      r = '0; c = 1'b0; v = 1'b0; lat = 2;
      case (op)
         6'b100000: begin
            s = int'(a) + int'(b); r = s[7:0]; c = (s >= 256);
            sr = sa + sb; v = (sr > 127) || (sr < -128);
         end
         6'b100010: begin
            s = int'(a) - int'(b); r = s[7:0]; c = (a >= b);
            sr = sa - sb; v = (sr > 127) || (sr < -128);
         end
         6'b100100: r = a & b;
         6'b100101: r = a | b;
         6'b100110: r = a ^ b;
         6'b100111: r = ~(a | b);
         6'b000000: begin r = a << sh; c = (sh > 0) ? a[8-sh] : 1'b0; lat = 2 + sh; end
         6'b000010: begin r = a >> sh; c = (sh > 0) ? a[sh-1] : 1'b0; lat = 2 + sh; end
         6'b000011: begin r = as_s >>> sh; c = (sh > 0) ? a[sh-1] : 1'b0; lat = 2 + sh; end
         default: ;
      endcase
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      i_enable_1 = 1'b1; i_data = a; tick(); i_enable_1 = 1'b0;
      i_enable_2 = 1'b1; i_data = b; tick(); i_enable_2 = 1'b0;
      i_enable_3 = 1'b1; i_data = {2'b00, op}; tick(); i_enable_3 = 1'b0;
      cur_a = a; cur_b = b; cur_op = op;
   endtask

   // Launch with the registers currently held; optionally hold DONE and
   // disturb it with a load of A plus a stray i_start.
   task automatic do_op(input string tag, input int hold, input bit disturb,
                        input logic [7:0] new_a);
      logic [7:0] er;
      logic ec, ev;
      int el, lat;
      model(cur_a, cur_b, cur_op, er, ec, ev, el);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      lat = 1;
      check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
      while (!o_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, el);
      check({tag, "_data"}, {24'd0, o_data}, {24'd0, er});
      check({tag, "_carry"}, {31'd0, o_carry}, {31'd0, ec});
      check({tag, "_zero"}, {31'd0, o_zero}, {31'd0, (er == 8'd0)});
`ifdef ALU_SIGNED_FLAGS_EN
      check({tag, "_ovf"}, {31'd0, o_overflow}, {31'd0, ev});
      check({tag, "_neg"}, {31'd0, o_negative}, {31'd0, er[7]});
`endif
      for (int i = 0; i < hold; i++) begin
         if (disturb && i == 2) begin
            i_enable_1 = 1'b1; i_data = new_a; i_start = 1'b1;
            tick();
            i_enable_1 = 1'b0; i_start = 1'b0;
            cur_a = new_a;
         end else begin
            tick();
         end
      end
      if (hold > 0) begin
         check({tag, "_held_valid"}, {31'd0, o_valid}, 32'd1);
         check({tag, "_held_data"}, {24'd0, o_data}, {24'd0, er});
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check({tag, "_release_valid"}, {31'd0, o_valid}, 32'd0);
      check({tag, "_release_busy"}, {31'd0, o_busy}, 32'd0);
   endtask

   initial begin : main
      logic [5:0] ops [10];
      ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
              6'b100111, 6'b000000, 6'b000010, 6'b000011, 6'b010101};

      repeat (3) tick();
      i_reset = 1'b0;
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_data", {24'd0, o_data}, 32'd0);
      check("rst_carry", {31'd0, o_carry}, 32'd0);
      check("rst_zero", {31'd0, o_zero}, 32'd0);

      load(8'hFF, 8'h01, 6'b100000); do_op("add_wrap", 0, 1'b0, 8'h00);
      load(8'h05, 8'h07, 6'b100010); do_op("sub_neg", 0, 1'b0, 8'h00);
      load(8'h80, 8'h01, 6'b100010); do_op("sub_ovf", 0, 1'b0, 8'h00);
      load(8'h81, 8'h03, 6'b000011); do_op("sra3", 0, 1'b0, 8'h00);
      check("sra3_const", {24'd0, o_data}, 32'h0000_00F0);
      load(8'h81, 8'h03, 6'b000010); do_op("srl3", 0, 1'b0, 8'h00);
      load(8'h81, 8'h03, 6'b000000); do_op("sll3", 0, 1'b0, 8'h00);
      load(8'h81, 8'h01, 6'b000000); do_op("sll1", 0, 1'b0, 8'h00);
      load(8'h81, 8'h00, 6'b000010); do_op("srl0", 0, 1'b0, 8'h00);

      // DONE held 10 cycles; new A and stray start must not disturb it
      load(8'h10, 8'h22, 6'b100000); do_op("hold", 10, 1'b1, 8'h40);
      check("hold_no_relaunch", {31'd0, o_busy}, 32'd0);
      do_op("after_hold", 0, 1'b0, 8'h00);

      // reset in the middle of a 7-bit shift
      load(8'hA5, 8'h07, 6'b000000);
      i_start = 1'b1; tick(); i_start = 1'b0;
      repeat (3) tick();
      i_reset = 1'b1; tick(); i_reset = 1'b0;
      check("midrst_busy", {31'd0, o_busy}, 32'd0);
      check("midrst_valid", {31'd0, o_valid}, 32'd0);
      check("midrst_data", {24'd0, o_data}, 32'd0);
      cur_a = '0; cur_b = '0; cur_op = '0;
      load(8'h3C, 8'h05, 6'b000010); do_op("post_rst", 0, 1'b0, 8'h00);

      load(8'h12, 8'h34, 6'b111111); do_op("bad_op", 0, 1'b0, 8'h00);

      // all enables together load only A
      i_enable_1 = 1'b1; i_enable_2 = 1'b1; i_enable_3 = 1'b1; i_data = 8'h5A;
      tick();
      i_enable_1 = 1'b0; i_enable_2 = 1'b0; i_enable_3 = 1'b0;
      cur_a = 8'h5A;
      do_op("enable_prio", 0, 1'b0, 8'h00);
      load(8'h5A, 8'h34, 6'b100000); do_op("enable_prio_add", 0, 1'b0, 8'h00);

      for (int k = 0; k < 40; k++) begin
         load(8'($urandom), 8'($urandom), ops[$urandom_range(0, 9)]);
         do_op("rand", int'($urandom_range(0, 2)), 1'b0, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
